// File: rtl/change_dispenser_if.sv
// Request/response bundle between the purchase controller and the change dispenser.
// The master side issues change requests and the slave side dispenses the pieces.
interface change_dispenser_if;
  logic       change_start;
  logic [7:0] change_amount;
  logic       dispense_abort;
  logic [4:0] empty_mask;
  logic       out_money_fifty;
  logic       out_money_twenty;
  logic       out_money_ten;
  logic       out_money_five;
  logic       out_money_one;
  logic       dispense_busy;
  logic       dispense_done;
  logic       dispense_error;
  logic [7:0] remaining_money;
  logic [7:0] pieces_out;

  modport master (
    output change_start, change_amount, dispense_abort, empty_mask,
    input  out_money_fifty, out_money_twenty, out_money_ten, out_money_five, out_money_one,
    input  dispense_busy, dispense_done, dispense_error, remaining_money, pieces_out
  );

  modport slave (
    input  change_start, change_amount, dispense_abort, empty_mask,
    output out_money_fifty, out_money_twenty, out_money_ten, out_money_five, out_money_one,
    output dispense_busy, dispense_done, dispense_error, remaining_money, pieces_out
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount in 50/20/10/5/1 pieces, one paced pulse
// per piece for the hopper, and reports done, abort or shortage.
module change_dispenser #(
  parameter int GAP_CYCLES = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  change_dispenser_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PULSE, GAP, DONE, ERROR} state_t;

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] gap_cnt, gap_cnt_nx;
  logic [7:0]    remaining, remaining_nx;
  logic [7:0]    pieces, pieces_nx;
  logic [4:0]    pulse, pulse_nx;
  logic [4:0]    coin_sel;
  logic [7:0]    coin_val;

  // Largest available denomination that still fits; mask is live every evaluation.
  always_comb begin
    coin_sel = '0;
    coin_val = '0;
    if (!bus.empty_mask[4] && remaining >= 8'd50) begin
      coin_sel = 5'b10000;
      coin_val = 8'd50;
    end else if (!bus.empty_mask[3] && remaining >= 8'd20) begin
      coin_sel = 5'b01000;
      coin_val = 8'd20;
    end else if (!bus.empty_mask[2] && remaining >= 8'd10) begin
      coin_sel = 5'b00100;
      coin_val = 8'd10;
    end else if (!bus.empty_mask[1] && remaining >= 8'd5) begin
      coin_sel = 5'b00010;
      coin_val = 8'd5;
    end else if (!bus.empty_mask[0] && remaining >= 8'd1) begin
      coin_sel = 5'b00001;
      coin_val = 8'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx     = state;
    gap_cnt_nx   = gap_cnt;
    remaining_nx = remaining;
    pieces_nx    = pieces;
    pulse_nx     = '0;
    case (state)
      IDLE: begin
        if (bus.change_start) begin
          remaining_nx = bus.change_amount;
          pieces_nx    = '0;
          state_nx     = (bus.change_amount != 8'd0) ? PULSE : DONE;
        end
      end
      PULSE: begin
        if (bus.dispense_abort) begin
          state_nx = IDLE;
        end else if (coin_sel != 5'b00000) begin
          pulse_nx     = coin_sel;
          remaining_nx = remaining - coin_val;
          pieces_nx    = (pieces == 8'hFF) ? pieces : pieces + 8'd1;
          gap_cnt_nx   = '0;
          state_nx     = (remaining == coin_val) ? DONE : GAP;
        end else begin
          state_nx = ERROR;
        end
      end
      GAP: begin
        if (bus.dispense_abort) begin
          state_nx = IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          state_nx = PULSE;
        end else begin
          gap_cnt_nx = gap_cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      ERROR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      remaining <= '0;
      pieces    <= '0;
      pulse     <= '0;
    end else begin
      state     <= state_nx;
      gap_cnt   <= gap_cnt_nx;
      remaining <= remaining_nx;
      pieces    <= pieces_nx;
      pulse     <= pulse_nx;
    end
  end

  assign bus.out_money_fifty  = pulse[4];
  assign bus.out_money_twenty = pulse[3];
  assign bus.out_money_ten    = pulse[2];
  assign bus.out_money_five   = pulse[1];
  assign bus.out_money_one    = pulse[0];
  assign bus.dispense_busy    = (state == PULSE) || (state == GAP);
  assign bus.dispense_done    = (state == DONE);
  assign bus.dispense_error   = (state == ERROR);
  assign bus.remaining_money  = remaining;
  assign bus.pieces_out       = pieces;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with GAP_CYCLES=4; cycle k counts from the
// cycle after the edge that samples change_start (k=1 is the first PULSE cycle).
module tb_change_dispenser;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  change_dispenser_if bus ();

  change_dispenser #(.GAP_CYCLES(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [4:0] pulses();
    return {bus.out_money_fifty, bus.out_money_twenty, bus.out_money_ten,
            bus.out_money_five, bus.out_money_one};
  endfunction

  // Request issued at one negedge, sampled at edge N; returns inside cycle N+1.
  task automatic start_txn(input logic [7:0] amount, input logic [4:0] mask);
    @(negedge sys_clk);
    bus.change_amount = amount;
    bus.empty_mask    = mask;
    bus.change_start  = 1'b1;
    @(negedge sys_clk);
    bus.change_start  = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] got;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    got = {pulses(), bus.dispense_busy, bus.dispense_done, bus.dispense_error,
           bus.remaining_money, bus.pieces_out, 5'd0};
    vectors++;
    if (got !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", got);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_amount_36();
    logic [4:0] exp_p;
    start_txn(8'd36, 5'b00000);
    for (int k = 1; k <= 20; k++) begin
      exp_p = (k == 2)  ? 5'b01000 : (k == 7)  ? 5'b00100 :
              (k == 12) ? 5'b00010 : (k == 17) ? 5'b00001 : 5'b00000;
      vectors++;
      if ({pulses(), bus.dispense_busy, bus.dispense_done, bus.dispense_error} !==
          {exp_p, (k <= 16), (k == 17), 1'b0}) begin
        miscompares++;
        $display("FAIL amt36_cycle%0d: got p=%b b=%b d=%b e=%b expected p=%b b=%b d=%b e=0",
                 k, pulses(), bus.dispense_busy, bus.dispense_done, bus.dispense_error,
                 exp_p, (k <= 16), (k == 17));
      end
      @(negedge sys_clk);
    end
    vectors++;
    if (bus.remaining_money !== 8'd0 || bus.pieces_out !== 8'd4) begin
      miscompares++;
      $display("FAIL amt36_totals: got rem=%0d pieces=%0d expected rem=0 pieces=4",
               bus.remaining_money, bus.pieces_out);
    end
  endtask

  task automatic test_zero();
    start_txn(8'd0, 5'b00000);
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if ({pulses(), bus.dispense_busy, bus.dispense_done} !== {5'b00000, 1'b0, (k == 1)}) begin
        miscompares++;
        $display("FAIL zero_cycle%0d: got p=%b b=%b d=%b expected p=0 b=0 d=%b",
                 k, pulses(), bus.dispense_busy, bus.dispense_done, (k == 1));
      end
      @(negedge sys_clk);
    end
    vectors++;
    if (bus.remaining_money !== 8'd0 || bus.pieces_out !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_totals: got rem=%0d pieces=%0d expected 0 0",
               bus.remaining_money, bus.pieces_out);
    end
  endtask

  task automatic test_fifty_empty();
    logic [4:0] exp_p;
    start_txn(8'd100, 5'b10000);
    for (int k = 1; k <= 25; k++) begin
      exp_p = (k >= 2 && k <= 22 && ((k - 2) % 5) == 0) ? 5'b01000 : 5'b00000;
      vectors++;
      if ({pulses(), bus.dispense_busy, bus.dispense_done} !== {exp_p, (k <= 21), (k == 22)}) begin
        miscompares++;
        $display("FAIL fifty_empty_cycle%0d: got p=%b b=%b d=%b expected p=%b b=%b d=%b",
                 k, pulses(), bus.dispense_busy, bus.dispense_done,
                 exp_p, (k <= 21), (k == 22));
      end
      @(negedge sys_clk);
    end
    vectors++;
    if (bus.remaining_money !== 8'd0 || bus.pieces_out !== 8'd5) begin
      miscompares++;
      $display("FAIL fifty_empty_totals: got rem=%0d pieces=%0d expected rem=0 pieces=5",
               bus.remaining_money, bus.pieces_out);
    end
  endtask

  task automatic test_shortage();
    start_txn(8'd13, 5'b00001);
    for (int k = 1; k <= 9; k++) begin
      vectors++;
      if ({pulses(), bus.dispense_busy, bus.dispense_done, bus.dispense_error} !==
          {((k == 2) ? 5'b00100 : 5'b00000), (k <= 6), 1'b0, (k == 7)}) begin
        miscompares++;
        $display("FAIL shortage_cycle%0d: got p=%b b=%b d=%b e=%b expected e=%b b=%b",
                 k, pulses(), bus.dispense_busy, bus.dispense_done, bus.dispense_error,
                 (k == 7), (k <= 6));
      end
      @(negedge sys_clk);
    end
    vectors++;
    if (bus.remaining_money !== 8'd3 || bus.pieces_out !== 8'd1) begin
      miscompares++;
      $display("FAIL shortage_totals: got rem=%0d pieces=%0d expected rem=3 pieces=1",
               bus.remaining_money, bus.pieces_out);
    end
  endtask

  task automatic test_abort();
    start_txn(8'd75, 5'b00000);
    @(negedge sys_clk);  // cycle 2: first pulse, then a start that must be ignored
    vectors++;
    if (pulses() !== 5'b10000) begin
      miscompares++;
      $display("FAIL abort_first_pulse: got %b expected 10000", pulses());
    end
    bus.change_amount = 8'd9;
    bus.change_start  = 1'b1;
    @(negedge sys_clk);  // cycle 3: still busy in GAP, raise abort
    bus.change_start   = 1'b0;
    bus.dispense_abort = 1'b1;
    vectors++;
    if (bus.dispense_busy !== 1'b1 || bus.remaining_money !== 8'd25) begin
      miscompares++;
      $display("FAIL abort_busy_start_ignored: got b=%b rem=%0d expected b=1 rem=25",
               bus.dispense_busy, bus.remaining_money);
    end
    @(negedge sys_clk);  // cycle 4: back in IDLE
    bus.dispense_abort = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      vectors++;
      if ({pulses(), bus.dispense_busy, bus.dispense_done, bus.dispense_error,
           bus.remaining_money, bus.pieces_out} !== {5'b0, 3'b000, 8'd25, 8'd1}) begin
        miscompares++;
        $display("FAIL abort_idle_cycle%0d: got p=%b b=%b d=%b e=%b rem=%0d pieces=%0d expected all 0, rem=25 pieces=1",
                 k, pulses(), bus.dispense_busy, bus.dispense_done, bus.dispense_error,
                 bus.remaining_money, bus.pieces_out);
      end
      @(negedge sys_clk);
    end
    start_txn(8'd6, 5'b00000);
    for (int k = 1; k <= 9; k++) begin
      vectors++;
      if ({pulses(), bus.dispense_done} !==
          {((k == 2) ? 5'b00010 : (k == 7) ? 5'b00001 : 5'b00000), (k == 7)}) begin
        miscompares++;
        $display("FAIL abort_restart_cycle%0d: got p=%b d=%b", k, pulses(), bus.dispense_done);
      end
      @(negedge sys_clk);
    end
    vectors++;
    if (bus.remaining_money !== 8'd0 || bus.pieces_out !== 8'd2) begin
      miscompares++;
      $display("FAIL abort_restart_totals: got rem=%0d pieces=%0d expected rem=0 pieces=2",
               bus.remaining_money, bus.pieces_out);
    end
  endtask

  task automatic test_reset_mid_gap();
    start_txn(8'd36, 5'b00000);
    repeat (2) @(negedge sys_clk);  // cycle 3, inside GAP
    sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({pulses(), bus.dispense_busy, bus.dispense_done, bus.dispense_error,
         bus.remaining_money, bus.pieces_out} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_mid_gap_immediate: got p=%b b=%b rem=%0d pieces=%0d expected 0",
               pulses(), bus.dispense_busy, bus.remaining_money, bus.pieces_out);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge sys_clk);
      vectors++;
      if ({pulses(), bus.dispense_busy, bus.dispense_done, bus.remaining_money} !== 15'd0) begin
        miscompares++;
        $display("FAIL reset_mid_gap_after%0d: got p=%b b=%b d=%b rem=%0d expected 0",
                 k, pulses(), bus.dispense_busy, bus.dispense_done, bus.remaining_money);
      end
    end
  endtask

  initial begin
    bus.change_start   = 1'b0;
    bus.change_amount  = 8'd0;
    bus.dispense_abort = 1'b0;
    bus.empty_mask     = 5'b00000;
    test_reset();
    test_amount_36();
    test_zero();
    test_fifty_empty();
    test_shortage();
    test_abort();
    test_reset_mid_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-dispensing sequencer for the vending machine. It sits downstream of the purchase state machine, which computes the change owed. The block accepts a change amount in yuan and decomposes it greedily into notes and coins (50/20/10/5/1). It emits one single-cycle dispense pulse per piece, paced for the mechanical hopper, and reports completion, abort or shortage.

## Interface
Parameters:
- GAP_CYCLES, 4: idle cycles between consecutive dispense pulses (≥1).

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  reset, asynchronous, active-low.
- change_start  input  1  request pulse; sampled only in IDLE.
- change_amount  input  8  change owed in yuan (0–255); latched with change_start.
- dispense_abort  input  1  abort request; honoured in PULSE/GAP only.
- empty_mask  input  5  hopper-empty flags: bit4=50, bit3=20, bit2=10, bit1=5, bit0=1; 1 = denomination unavailable.
- out_money_fifty / out_money_twenty / out_money_ten / out_money_five / out_money_one  output  1 each  registered one-cycle dispense pulses.
- dispense_busy  output  1  high in PULSE and GAP.
- dispense_done  output  1  one-cycle pulse on successful completion.
- dispense_error  output  1  one-cycle pulse when the remainder cannot be paid.
- remaining_money  output  8  undispensed amount.
- pieces_out  output  8  pieces dispensed in the current/last transaction.

## Operation
- States: IDLE, PULSE, GAP, DONE, ERROR.
- IDLE:
  - change_start=1 → load remaining_money=change_amount and clear pieces_out.
  - Next state is PULSE if the amount is nonzero, DONE if it is zero.
- PULSE:
  - Select the largest denomination d ≤ remaining_money whose empty_mask bit is 0.
  - Assert the matching out_money_* for one cycle.
  - Update remaining_money -= d and pieces_out += 1.
  - Next state is DONE if the new remainder is 0, otherwise GAP.
  - If no eligible d exists → ERROR, no pulse, remaining_money held.
- GAP: count GAP_CYCLES cycles, then go to PULSE.
- DONE: dispense_done=1 for one cycle, then IDLE.
- ERROR: dispense_error=1 for one cycle, then IDLE.
- dispense_abort=1 in PULSE or GAP:
  - Go to IDLE next edge.
  - Abort has priority over the PULSE action: no pulse, no decrement.
  - No done or error pulse.
  - remaining_money holds the undispensed value.
- change_start is ignored outside IDLE. dispense_abort is ignored in IDLE, DONE and ERROR.
- At most one out_money_* is high in any cycle.
- empty_mask is sampled at every PULSE evaluation, so a hopper can empty mid-transaction.
- Arithmetic is 8-bit unsigned. The decrement never underflows because d ≤ remainder. pieces_out saturates at 255, which is unreachable with valid masks.
- remaining_money and pieces_out persist in IDLE until the next accepted start.

## Timing
- Reset (asynchronous, any state, including mid-dispense):
  - state=IDLE.
  - All out_money_*, dispense_busy, dispense_done and dispense_error = 0.
  - remaining_money=0, pieces_out=0.
  - Pulses in flight are dropped.
- Cycle numbering: change_start is sampled at edge N. "Cycle N+k" is the cycle following edge N+k−1.
- The FSM is in PULSE during cycle N+1, and dispense_busy is high from cycle N+1.
- The first dispense pulse is high in cycle N+2. remaining_money and pieces_out update at the same edge.
- Consecutive pulses are spaced GAP_CYCLES+1 cycles apart.
- The final pulse and dispense_done are high in the same cycle. dispense_busy is low in that cycle.
- Zero amount: dispense_done is high in cycle N+1, with no pulses and no busy.
- Error: dispense_error is high in the cycle after the failing PULSE cycle.
- Abort sampled at edge M: IDLE and busy=0 from cycle M+1, with no pulse in cycle M+1.

## Test plan
- Amount 36, mask 0, GAP=4, start at edge N:
  - twenty at cycle N+2, ten at N+7, five at N+12, one at N+17.
  - done at N+17; remaining 0; pieces_out 4.
- Amount 0: done at N+1; no out_money_* pulse; busy never high.
- Amount 100 with mask=5'b10000 (fifty empty):
  - five twenty pulses, done with the fifth.
  - pieces_out 5.
- Amount 13 with mask=5'b00001 (ones empty):
  - ten, then one five cannot be taken since 3 < 5, so ERROR.
  - dispense_error pulse; remaining_money=3; pieces_out=1.
- Amount 75, dispense_abort asserted during the GAP after the first pulse:
  - only fifty dispensed; remaining_money=25.
  - no done; IDLE next cycle.
  - a start issued during busy is ignored; a new start afterwards is accepted.
- Reset asserted mid-GAP: all outputs 0 immediately; no further pulses after release.
